rtc_timekeeper: RTL and testbench

Parametrised successor to the fixed 50 MHz HH:MM:SS.sub clock counter. It keeps wall-clock time from a configurable input clock and sub-second resolution, and adds run/pause, time load, lap capture with a valid/ack handshake, a daily alarm, and single-cycle second and day strobes. It sits beside the raycaster display logic and feeds the on-screen timer/HUD and frame-timing code.

---
 rtl/rtc_timekeeper.sv | 205 ++++++++++++++++++++
 tb/tb_rtc_timekeeper.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timekeeper.sv
// Wall-clock timekeeper: clock divider feeding HH:MM:SS.sub fields, with load,
// run/pause, lap capture (valid/ack), a daily alarm and second/day strobes.
module rtc_timekeeper #(
  parameter int CLK_HZ    = 50000000,
  parameter int SUB_HZ    = 100000,
  parameter int SUB_W     = 17,
  parameter int HOUR_WRAP = 24
) (
  input  logic             clock50MHz,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [5:0]       loadH,
  input  logic [5:0]       loadM,
  input  logic [5:0]       loadS,
  input  logic [SUB_W-1:0] loadSub,
  input  logic             lapStrobe,
  input  logic             lapAck,
  input  logic             alarmEnable,
  input  logic [5:0]       alarmH,
  input  logic [5:0]       alarmM,
  input  logic [5:0]       alarmS,
  output logic [5:0]       hours,
  output logic [5:0]       minutes,
  output logic [5:0]       seconds,
  output logic [SUB_W-1:0] subSeconds,
  output logic [5:0]       lapH,
  output logic [5:0]       lapM,
  output logic [5:0]       lapS,
  output logic [SUB_W-1:0] lapSub,
  output logic             lapValid,
  output logic             lapOverrun,
  output logic             loadError,
  output logic             secondTick,
  output logic             dayWrap,
  output logic             alarmPulse
);

  localparam int DIV   = CLK_HZ / SUB_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SUB_HZ - 1);
  localparam logic [SUB_W:0]   SUB_LIMIT  = (SUB_W + 1)'(SUB_HZ);
  localparam logic [6:0]       HOUR_LIMIT = 7'(HOUR_WRAP);
  localparam logic [5:0]       HOUR_LAST  = 6'(HOUR_WRAP - 1);
  localparam logic [5:0]       MS_LAST    = 6'd59;

  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [SUB_W-1:0] sub_q, sub_d;

  logic [5:0]       lap_hr_q, lap_hr_d, lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
  logic [SUB_W-1:0] lap_sub_q, lap_sub_d;
  logic             lap_valid_q, lap_valid_d;
  logic             lap_ovr_q, lap_ovr_d;

  logic load_err_q, load_err_d;
  logic sec_tick_q, sec_tick_d;
  logic day_wrap_q, day_wrap_d;
  logic alarm_q, alarm_d;

  logic             load_ok;
  logic             tick;
  logic             sub_wrap, sec_wrap, min_wrap, hr_wrap;
  logic [5:0]       inc_hr, inc_min, inc_sec;
  logic [SUB_W-1:0] inc_sub;

  assign load_ok = load
                 && ({1'b0, loadH} < HOUR_LIMIT)
                 && (loadM <= MS_LAST)
                 && (loadS <= MS_LAST)
                 && ({1'b0, loadSub} < SUB_LIMIT);

  assign tick = run && (div_q == DIV_LAST);

  // Full ripple of one sub-second increment; every field settles in the same edge.
  always_comb begin : increment
    sub_wrap = (sub_q == SUB_LAST);
    sec_wrap = sub_wrap && (sec_q == MS_LAST);
    min_wrap = sec_wrap && (min_q == MS_LAST);
    hr_wrap  = min_wrap && (hr_q == HOUR_LAST);

    inc_sub = sub_wrap ? '0 : sub_q + 1'b1;
    inc_sec = sec_wrap ? '0 : (sub_wrap ? sec_q + 6'd1 : sec_q);
    inc_min = min_wrap ? '0 : (sec_wrap ? min_q + 6'd1 : min_q);
    inc_hr  = hr_wrap  ? '0 : (min_wrap ? hr_q  + 6'd1 : hr_q);
  end

  always_comb begin : next_time
    div_d      = div_q;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sub_d      = sub_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    alarm_d    = 1'b0;
    load_err_d = load && !load_ok;

    if (load_ok) begin
      div_d = '0;
      hr_d  = loadH;
      min_d = loadM;
      sec_d = loadS;
      sub_d = loadSub;
    end else if (run) begin
      if (tick) begin
        div_d      = '0;
        hr_d       = inc_hr;
        min_d      = inc_min;
        sec_d      = inc_sec;
        sub_d      = inc_sub;
        sec_tick_d = sub_wrap;
        day_wrap_d = hr_wrap;
        // Out-of-range alarm fields can never equal an in-range count.
        alarm_d    = alarmEnable
                   && (inc_hr == alarmH)
                   && (inc_min == alarmM)
                   && (inc_sec == alarmS)
                   && (inc_sub == '0);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin : next_lap
    lap_hr_d    = lap_hr_q;
    lap_min_d   = lap_min_q;
    lap_sec_d   = lap_sec_q;
    lap_sub_d   = lap_sub_q;
    lap_valid_d = lap_valid_q;
    lap_ovr_d   = 1'b0;

    if (lapStrobe) begin
      lap_hr_d    = hr_q;
      lap_min_d   = min_q;
      lap_sec_d   = sec_q;
      lap_sub_d   = sub_q;
      lap_valid_d = 1'b1;
      lap_ovr_d   = lap_valid_q && !lapAck;
    end else if (lapAck) begin
      lap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      div_q      <= '0;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sub_q      <= '0;
      load_err_q <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sub_q      <= sub_d;
      load_err_q <= load_err_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      alarm_q    <= alarm_d;
    end
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      lap_hr_q    <= '0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_sub_q   <= '0;
      lap_valid_q <= 1'b0;
      lap_ovr_q   <= 1'b0;
    end else begin
      lap_hr_q    <= lap_hr_d;
      lap_min_q   <= lap_min_d;
      lap_sec_q   <= lap_sec_d;
      lap_sub_q   <= lap_sub_d;
      lap_valid_q <= lap_valid_d;
      lap_ovr_q   <= lap_ovr_d;
    end
  end

  assign hours      = hr_q;
  assign minutes    = min_q;
  assign seconds    = sec_q;
  assign subSeconds = sub_q;
  assign lapH       = lap_hr_q;
  assign lapM       = lap_min_q;
  assign lapS       = lap_sec_q;
  assign lapSub     = lap_sub_q;
  assign lapValid   = lap_valid_q;
  assign lapOverrun = lap_ovr_q;
  assign loadError  = load_err_q;
  assign secondTick = sec_tick_q;
  assign dayWrap    = day_wrap_q;
  assign alarmPulse = alarm_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: vector table, directed corner sequences and a
// randomized run checked every cycle against a flat "ticks since midnight" model.
module tb_rtc_timekeeper;

  localparam int CLK_HZ    = 1000;
  localparam int SUB_HZ    = 100;
  localparam int SUB_W     = 7;
  localparam int HOUR_WRAP = 24;
  localparam int DIV       = CLK_HZ / SUB_HZ;
  localparam int DAY       = HOUR_WRAP * 3600 * SUB_HZ;

  logic clk;
  logic rst, run, load, lap_stb, lap_ack, al_en;
  logic [5:0] lh, lm, ls, al_h, al_m, al_s;
  logic [SUB_W-1:0] lsub;

  logic [5:0] hours, minutes, seconds, lapH, lapM, lapS;
  logic [SUB_W-1:0] subSeconds, lapSub;
  logic lapValid, lapOverrun, loadError, secondTick, dayWrap, alarmPulse;

  rtc_timekeeper #(
    .CLK_HZ(CLK_HZ), .SUB_HZ(SUB_HZ), .SUB_W(SUB_W), .HOUR_WRAP(HOUR_WRAP)
  ) dut (
    .clock50MHz(clk), .reset(rst), .run(run), .load(load),
    .loadH(lh), .loadM(lm), .loadS(ls), .loadSub(lsub),
    .lapStrobe(lap_stb), .lapAck(lap_ack),
    .alarmEnable(al_en), .alarmH(al_h), .alarmM(al_m), .alarmS(al_s),
    .hours(hours), .minutes(minutes), .seconds(seconds), .subSeconds(subSeconds),
    .lapH(lapH), .lapM(lapM), .lapS(lapS), .lapSub(lapSub),
    .lapValid(lapValid), .lapOverrun(lapOverrun), .loadError(loadError),
    .secondTick(secondTick), .dayWrap(dayWrap), .alarmPulse(alarmPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time is one integer count of sub-second ticks since midnight.
  int m_div, m_total, m_lh, m_lm, m_ls, m_lsub;
  bit m_lv, m_ov, m_lerr, m_st, m_dw, m_ap;

  function automatic int f_h(input int t);   return t / (3600 * SUB_HZ);      endfunction
  function automatic int f_m(input int t);   return (t / (60 * SUB_HZ)) % 60; endfunction
  function automatic int f_s(input int t);   return (t / SUB_HZ) % 60;        endfunction
  function automatic int f_sub(input int t); return t % SUB_HZ;               endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int at;
    bit ok, al_ok;
    m_st = 0; m_dw = 0; m_ap = 0; m_lerr = 0; m_ov = 0;
    if (rst) begin
      m_div = 0; m_total = 0;
      m_lh = 0; m_lm = 0; m_ls = 0; m_lsub = 0; m_lv = 0;
    end else begin
      if (lap_stb) begin
        m_ov   = m_lv && !lap_ack;
        m_lh   = f_h(m_total);
        m_lm   = f_m(m_total);
        m_ls   = f_s(m_total);
        m_lsub = f_sub(m_total);
        m_lv   = 1;
      end else if (lap_ack) begin
        m_lv = 0;
      end
      ok = load && (int'(lh) < HOUR_WRAP) && (int'(lm) < 60) && (int'(ls) < 60)
                && (int'(lsub) < SUB_HZ);
      if (ok) begin
        m_total = ((int'(lh) * 60 + int'(lm)) * 60 + int'(ls)) * SUB_HZ + int'(lsub);
        m_div   = 0;
      end else begin
        m_lerr = load;
        if (run) begin
          m_div++;
          if (m_div == DIV) begin
            m_div   = 0;
            m_total = (m_total + 1) % DAY;
            m_st    = (m_total % SUB_HZ) == 0;
            m_dw    = (m_total == 0);
            al_ok   = (int'(al_h) < HOUR_WRAP) && (int'(al_m) < 60) && (int'(al_s) < 60);
            at      = ((int'(al_h) * 60 + int'(al_m)) * 60 + int'(al_s)) * SUB_HZ;
            m_ap    = al_en && al_ok && (m_total == at);
          end
        end
      end
    end
  endtask

  task automatic check_model();
    check("model_time", 64'({hours, minutes, seconds, subSeconds}),
          64'({6'(f_h(m_total)), 6'(f_m(m_total)), 6'(f_s(m_total)), 7'(f_sub(m_total))}));
    check("model_lap", 64'({lapH, lapM, lapS, lapSub}),
          64'({6'(m_lh), 6'(m_lm), 6'(m_ls), 7'(m_lsub)}));
    check("model_flags", 64'({lapValid, lapOverrun, loadError, secondTick, dayWrap, alarmPulse}),
          64'({m_lv, m_ov, m_lerr, m_st, m_dw, m_ap}));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  typedef struct {
    logic rst, run, load;
    logic [5:0] lh, lm, ls;
    logic [6:0] lsub;
    logic lstb, lack;
    logic [5:0] eh, em, es;
    logic [6:0] esub;
    logic elerr, elv, elov;
    logic [6:0] elsub;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic rn, input logic ld,
    input logic [5:0] h, input logic [5:0] mi, input logic [5:0] s, input logic [6:0] sb,
    input logic st, input logic ak,
    input logic [5:0] eh, input logic [5:0] em, input logic [5:0] es, input logic [6:0] esb,
    input logic ele, input logic elv, input logic elo, input logic [6:0] els);
    vec_t v;
    v.rst = r; v.run = rn; v.load = ld; v.lh = h; v.lm = mi; v.ls = s; v.lsub = sb;
    v.lstb = st; v.lack = ak; v.eh = eh; v.em = em; v.es = es; v.esub = esb;
    v.elerr = ele; v.elv = elv; v.elov = elo; v.elsub = els;
    return v;
  endfunction

  vec_t tbl[13];
  int n_alarm, n_bad;

  initial begin
    rst = 1; run = 0; load = 0; lap_stb = 0; lap_ack = 0; al_en = 0;
    lh = 0; lm = 0; ls = 0; lsub = 0; al_h = 0; al_m = 0; al_s = 0;
    m_div = 0; m_total = 0; m_lh = 0; m_lm = 0; m_ls = 0; m_lsub = 0;
    m_lv = 0; m_ov = 0; m_lerr = 0; m_st = 0; m_dw = 0; m_ap = 0;

    // Single-cycle vectors, applied back to back with run=0.
    tbl[0]  = mk(1,0,0, 6'd0,6'd0,6'd0,7'd0,      0,0, 6'd0,6'd0,6'd0,7'd0,      0,0,0,7'd0);
    tbl[1]  = mk(0,0,1, 6'd12,6'd34,6'd56,7'd78,  0,0, 6'd12,6'd34,6'd56,7'd78,  0,0,0,7'd0);
    tbl[2]  = mk(0,0,1, 6'd1,6'd2,6'd60,7'd3,     0,0, 6'd12,6'd34,6'd56,7'd78,  1,0,0,7'd0);
    tbl[3]  = mk(0,0,1, 6'd24,6'd0,6'd0,7'd0,     0,0, 6'd12,6'd34,6'd56,7'd78,  1,0,0,7'd0);
    tbl[4]  = mk(0,0,1, 6'd0,6'd0,6'd0,7'd100,    0,0, 6'd12,6'd34,6'd56,7'd78,  1,0,0,7'd0);
    tbl[5]  = mk(0,0,1, 6'd0,6'd60,6'd0,7'd0,     0,0, 6'd12,6'd34,6'd56,7'd78,  1,0,0,7'd0);
    tbl[6]  = mk(0,0,0, 6'd0,6'd0,6'd0,7'd0,      0,0, 6'd12,6'd34,6'd56,7'd78,  0,0,0,7'd0);
    tbl[7]  = mk(0,0,0, 6'd0,6'd0,6'd0,7'd0,      1,0, 6'd12,6'd34,6'd56,7'd78,  0,1,0,7'd78);
    tbl[8]  = mk(0,0,0, 6'd0,6'd0,6'd0,7'd0,      1,0, 6'd12,6'd34,6'd56,7'd78,  0,1,1,7'd78);
    tbl[9]  = mk(0,0,0, 6'd0,6'd0,6'd0,7'd0,      1,1, 6'd12,6'd34,6'd56,7'd78,  0,1,0,7'd78);
    tbl[10] = mk(0,0,0, 6'd0,6'd0,6'd0,7'd0,      0,1, 6'd12,6'd34,6'd56,7'd78,  0,0,0,7'd78);
    tbl[11] = mk(0,0,1, 6'd23,6'd59,6'd59,7'd99,  0,0, 6'd23,6'd59,6'd59,7'd99,  0,0,0,7'd78);
    tbl[12] = mk(1,0,1, 6'd1,6'd1,6'd1,7'd1,      0,0, 6'd0,6'd0,6'd0,7'd0,      0,0,0,7'd0);

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; run = tbl[i].run; load = tbl[i].load;
      lh = tbl[i].lh; lm = tbl[i].lm; ls = tbl[i].ls; lsub = tbl[i].lsub;
      lap_stb = tbl[i].lstb; lap_ack = tbl[i].lack;
      step();
      check($sformatf("vec%0d_time", i), 64'({hours, minutes, seconds, subSeconds}),
            64'({tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].esub}));
      check($sformatf("vec%0d_flags", i), 64'({loadError, lapValid, lapOverrun, lapSub}),
            64'({tbl[i].elerr, tbl[i].elv, tbl[i].elov, tbl[i].elsub}));
    end
    rst = 0; load = 0; lap_stb = 0; lap_ack = 0;

    // Counting from reset, first second, and a once-only alarm at 00:00:01.
    rst = 1; step(); rst = 0;
    run = 1; al_en = 1; al_h = 0; al_m = 0; al_s = 1;
    n_alarm = 0;
    for (int i = 1; i <= 9; i++) begin step(); n_alarm += int'(alarmPulse); end
    check("sub_before_edge10", 64'(subSeconds), 64'd0);
    step(); n_alarm += int'(alarmPulse);
    check("sub_at_edge10", 64'(subSeconds), 64'd1);
    for (int i = 11; i <= 999; i++) begin step(); n_alarm += int'(alarmPulse); end
    check("time_edge999", 64'({seconds, subSeconds, secondTick}), 64'({6'd0, 7'd99, 1'b0}));
    step(); n_alarm += int'(alarmPulse);
    check("time_edge1000", 64'({seconds, subSeconds}), 64'({6'd1, 7'd0}));
    check("tick_edge1000", 64'({secondTick, alarmPulse}), 64'(2'b11));
    step(); n_alarm += int'(alarmPulse);
    check("tick_edge1001", 64'({secondTick, alarmPulse}), 64'(2'b00));
    for (int i = 0; i < 100; i++) begin step(); n_alarm += int'(alarmPulse); end
    check("alarm_once", 64'(n_alarm), 64'd1);
    load = 1; lh = 0; lm = 0; ls = 1; lsub = 0;
    step(); load = 0;
    check("load_no_alarm", 64'({hours, minutes, seconds, subSeconds, alarmPulse, secondTick}),
          64'({6'd0, 6'd0, 6'd1, 7'd0, 1'b0, 1'b0}));

    // Day wrap from 23:59:59.99 with alarm disarmed at midnight.
    al_en = 0; al_h = 0; al_m = 0; al_s = 0;
    load = 1; lh = 23; lm = 59; ls = 59; lsub = 99;
    step(); load = 0;
    check("load_2359", 64'({hours, minutes, seconds, subSeconds, secondTick}),
          64'({6'd23, 6'd59, 6'd59, 7'd99, 1'b0}));
    n_bad = 0;
    for (int i = 0; i < 9; i++) begin
      step(); n_bad += int'(dayWrap | secondTick | alarmPulse);
    end
    check("no_strobe_pre_wrap", 64'(n_bad), 64'd0);
    step();
    check("wrap_time", 64'({hours, minutes, seconds, subSeconds}), 64'd0);
    check("wrap_strobes", 64'({dayWrap, secondTick, alarmPulse}), 64'(3'b110));
    step();
    check("wrap_strobes_next", 64'({dayWrap, secondTick}), 64'(2'b00));

    // Pause mid-divider and resume without lost or extra cycles.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 5; i++) step();
    run = 0;
    for (int i = 0; i < 50; i++) step();
    check("paused_sub", 64'(subSeconds), 64'd0);
    run = 1;
    for (int i = 0; i < 4; i++) step();
    check("resume_4", 64'(subSeconds), 64'd0);
    step();
    check("resume_5", 64'(subSeconds), 64'd1);

    // Lap capture, overrun and acknowledge.
    run = 0;
    load = 1; lh = 0; lm = 0; ls = 0; lsub = 42; step(); load = 0;
    lap_stb = 1; step(); lap_stb = 0;
    check("lap_first", 64'({lapSub, lapValid, lapOverrun}), 64'({7'd42, 1'b1, 1'b0}));
    load = 1; lsub = 43; step(); load = 0;
    lap_stb = 1; step(); lap_stb = 0;
    check("lap_overrun", 64'({lapSub, lapValid, lapOverrun}), 64'({7'd43, 1'b1, 1'b1}));
    step();
    check("lap_overrun_end", 64'({lapValid, lapOverrun}), 64'(2'b10));
    lap_ack = 1; step(); lap_ack = 0;
    check("lap_acked", 64'(lapValid), 64'd0);

    // Rejected load keeps counting; load together with reset yields all zeros.
    run = 1;
    for (int i = 0; i < 37; i++) step();
    load = 1; lh = 5; lm = 6; ls = 60; lsub = 7; step(); load = 0;
    check("bad_load_err", 64'(loadError), 64'd1);
    step();
    check("bad_load_err_end", 64'(loadError), 64'd0);
    lap_stb = 1; step(); lap_stb = 0;
    load = 1; rst = 1; lh = 1; lm = 2; ls = 3; lsub = 4; step(); load = 0; rst = 0;
    check("reset_wins", 64'({hours, minutes, seconds, subSeconds, lapH, lapM, lapS, lapSub}), 64'd0);
    check("reset_wins_flags",
          64'({lapValid, lapOverrun, loadError, secondTick, dayWrap, alarmPulse}), 64'd0);

    // Randomized run against the model.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 20000; i++) begin
      rst     = ($urandom_range(0, 4999) == 0);
      run     = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 99) == 0);
      lap_stb = ($urandom_range(0, 15) == 0);
      lap_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        al_en = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: begin al_h = 0;  al_m = 0;  al_s = 0;  end
          1: begin al_h = 23; al_m = 59; al_s = 59; end
          2: begin al_h = 6'($urandom_range(0, 25)); al_m = 6'($urandom_range(58, 61));
                   al_s = 6'($urandom_range(0, 60)); end
          default: begin al_h = 0; al_m = 0; al_s = 1; end
        endcase
      end
      if (load) begin
        case ($urandom_range(0, 3))
          0: begin lh = 23; lm = 59; ls = 6'($urandom_range(58, 59));
                   lsub = 7'($urandom_range(95, 99)); end
          1: begin lh = 6'($urandom_range(0, 23)); lm = 6'($urandom_range(0, 59));
                   ls = 6'($urandom_range(0, 59)); lsub = 7'($urandom_range(0, 99)); end
          2: begin lh = 6'($urandom_range(0, 26)); lm = 6'($urandom_range(0, 63));
                   ls = 6'($urandom_range(0, 63)); lsub = 7'($urandom_range(0, 127)); end
          default: begin lh = 6'($urandom_range(0, 23)); lm = 59; ls = 59;
                   lsub = 7'($urandom_range(90, 99)); end
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
